alsu_core: RTL
==============

Name: alsu_core

Overview:
- Registered arithmetic/logic/shift unit: the datapath whose outputs the ALSU assertion checker bound to ALSU_if verifies.
- Stage 1 samples all operands and controls.
- Stage 2 computes and registers out and leds. Results are visible two sampling edges after the operands are presented.
- Adds an in_valid/out_valid qualifier so upstream sequencers can stall the unit without corrupting shift or rotate state.

Parameters:
- INPUT_PRIORITY, "A", which operand wins when both red_op_* or both bypass_* are set ("A" or "B").
- FULL_ADDER, "ON", "ON" adds cin into ADD; "OFF" ignores cin.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/controls valid this cycle.
- A  in  3  signed operand A.
- B  in  3  signed operand B.
- opcode  in  3  0 OR, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE, 6/7 invalid.
- cin  in  1  carry in for ADD.
- serial_in  in  1  shift fill bit.
- direction  in  1  1 = left, 0 = right.
- red_op_A  in  1  reduction on A (OR/XOR only).
- red_op_B  in  1  reduction on B (OR/XOR only).
- bypass_A  in  1  pass A to out.
- bypass_B  in  1  pass B to out.
- out  out  6  signed result register.
- leds  out  16  error indicator register.
- out_valid  out  1  out/leds updated on the last edge.

Behaviour:
- Reset (reset=0, asynchronous): stage-1 registers, out, leds and out_valid all clear to 0. On reset deassertion, operation resumes at the next posedge.
- Stage 1: on a posedge with in_valid=1, latch all inputs and set v1=1. With in_valid=0, set v1=0 and leave the latched inputs unchanged.
- Stage 2: on a posedge with v1=1, out and leds update from the latched values and out_valid=1. With v1=0, out and leds hold and out_valid=0.
- Latency: inputs presented at edge N produce out at edge N+1, sampled by the checker at edge N+2.
- Invalid condition:
  - opcode 6 or 7, or
  - (red_op_A or red_op_B) with opcode not 0/1.
  - Effect: out=0 and leds=~leds (toggle on every valid cycle). The invalid condition takes priority over bypass.
- Valid cycle: leds=0.
- Bypass priority (valid op):
  - bypass_A and bypass_B: out = sign-extended A if INPUT_PRIORITY="A", else B.
  - Only one bypass set: out = that operand.
- Operations (no bypass):
  - OR: with red_op_A (priority per INPUT_PRIORITY) out = |A; with red_op_B out = |B; otherwise out = A|B sign-extended.
  - XOR: same reduction selection with ^; otherwise out = A^B sign-extended.
  - ADD: out = A+B+(FULL_ADDER=="ON" ? cin : 0), signed, 6 bits, no overflow possible.
  - MULT: out = A*B signed; -4*-4 = 16 fits in 6 bits.
  - SHIFT: direction=1 gives out={out[4:0],serial_in}; direction=0 gives out={serial_in,out[5:1]}. The shift uses the current out register.
  - ROTATE: direction=1 gives out={out[4:0],out[5]}; direction=0 gives out={out[0],out[5:1]}.
- Stall: in_valid=0 freezes out, so a shift/rotate sequence resumes exactly where it stopped.
- Reset mid-shift: out clears to 0 and the next shift starts from 0.

Decomposition:
- alsu_pkg holds:
  - opcode enum: OR, XOR, ADD, MULT, SHIFT, ROTATE, INV6, INV7;
  - width constants: IN_W=3, OUT_W=6, LED_W=16.
- One sub-module, alsu_compute: combinational next-out and invalid flag, taking the stage-1 registers and the current out as inputs.
- alsu_core keeps the pipeline registers, the valid tracking and leds.

Test Plan:
- Reset held with random inputs for 3 cycles: out=0, leds=0, out_valid=0. Release, then A=3, B=-2, opcode=ADD, cin=1, no reductions/bypass: out=2 two edges later.
- opcode=MULT, A=-4, B=-4: out=16. Then A=3, B=-1: out=-3 (6'b111101).
- Reduction OR with red_op_A=1, red_op_B=1, A=0, B=3, INPUT_PRIORITY="A": out=0. Then red_op_B only: out=1.
- opcode=SHIFT, direction=1, serial_in=1 from out=0: four valid cycles give out=6'b001111. Deassert in_valid 2 cycles: out holds. ROTATE direction=0 once: out=6'b100111.
- opcode=6 for 3 consecutive valid cycles: out=0, leds = FFFF, 0000, FFFF. A following valid OR with A=1, B=2: out=3, leds=0.
- bypass_A=1, bypass_B=1, A=-1, B=2, opcode=XOR: out=-1 with INPUT_PRIORITY="A", out=2 with "B". Asynchronous reset asserted mid-cycle: out=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared types and widths for the ALSU datapath.
package alsu_pkg;

  localparam int IN_W  = 3;
  localparam int OUT_W = 6;
  localparam int LED_W = 16;

  typedef enum logic [2:0] {
    OR     = 3'd0,
    XOR    = 3'd1,
    ADD    = 3'd2,
    MULT   = 3'd3,
    SHIFT  = 3'd4,
    ROTATE = 3'd5,
    INV6   = 3'd6,
    INV7   = 3'd7
  } opcode_e;

  // Everything stage 1 captures from the input side.
  typedef struct packed {
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
    opcode_e         opcode;
    logic            cin;
    logic            serial_in;
    logic            direction;
    logic            red_a;
    logic            red_b;
    logic            byp_a;
    logic            byp_b;
  } stage1_t;

  function automatic logic [OUT_W-1:0] sext(input logic [IN_W-1:0] v);
    return {{(OUT_W-IN_W){v[IN_W-1]}}, v};
  endfunction

endpackage

// File: rtl/alsu_compute.sv
// Combinational next value of out plus the invalid-operation flag,
// derived from the stage-1 registers and the current out register.
module alsu_compute
  import alsu_pkg::*;
#(
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  stage1_t          s1_i,
  input  logic [OUT_W-1:0] out_i,
  output logic [OUT_W-1:0] out_next_o,
  output logic             invalid_o
);

  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] b_ext;
  logic             red_any;
  logic             use_red_a;
  logic [OUT_W-1:0] carry;

  always_comb begin
    a_ext     = sext(s1_i.a);
    b_ext     = sext(s1_i.b);
    red_any   = s1_i.red_a || s1_i.red_b;
    // When both reductions are requested the priority operand decides.
    use_red_a = s1_i.red_a && (PRIO_A || !s1_i.red_b);
    carry     = {{(OUT_W-1){1'b0}}, s1_i.cin & USE_CIN};
    invalid_o = (s1_i.opcode == INV6) || (s1_i.opcode == INV7) ||
                (red_any && (s1_i.opcode != OR) && (s1_i.opcode != XOR));

    out_next_o = '0;
    if (invalid_o) begin
      out_next_o = '0;
    end else if (s1_i.byp_a && s1_i.byp_b) begin
      out_next_o = PRIO_A ? a_ext : b_ext;
    end else if (s1_i.byp_a) begin
      out_next_o = a_ext;
    end else if (s1_i.byp_b) begin
      out_next_o = b_ext;
    end else begin
      case (s1_i.opcode)
        OR: begin
          if (use_red_a)       out_next_o = {{(OUT_W-1){1'b0}}, |s1_i.a};
          else if (s1_i.red_b) out_next_o = {{(OUT_W-1){1'b0}}, |s1_i.b};
          else                 out_next_o = a_ext | b_ext;
        end
        XOR: begin
          if (use_red_a)       out_next_o = {{(OUT_W-1){1'b0}}, ^s1_i.a};
          else if (s1_i.red_b) out_next_o = {{(OUT_W-1){1'b0}}, ^s1_i.b};
          else                 out_next_o = a_ext ^ b_ext;
        end
        ADD:  out_next_o = a_ext + b_ext + carry;
        MULT: out_next_o = a_ext * b_ext;
        SHIFT: begin
          if (s1_i.direction) out_next_o = {out_i[OUT_W-2:0], s1_i.serial_in};
          else                out_next_o = {s1_i.serial_in, out_i[OUT_W-1:1]};
        end
        ROTATE: begin
          if (s1_i.direction) out_next_o = {out_i[OUT_W-2:0], out_i[OUT_W-1]};
          else                out_next_o = {out_i[0], out_i[OUT_W-1:1]};
        end
        default: out_next_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alsu_core.sv
// Two-stage registered ALSU: stage 1 captures operands/controls, stage 2
// registers out and leds. in_valid stalls without disturbing out.
module alsu_core
  import alsu_pkg::*;
#(
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  A,
  input  logic signed [IN_W-1:0]  B,
  input  logic [2:0]              opcode,
  input  logic                    cin,
  input  logic                    serial_in,
  input  logic                    direction,
  input  logic                    red_op_A,
  input  logic                    red_op_B,
  input  logic                    bypass_A,
  input  logic                    bypass_B,
  output logic signed [OUT_W-1:0] out,
  output logic [LED_W-1:0]        leds,
  output logic                    out_valid
);

  stage1_t          s1_in;
  stage1_t          s1_q, s1_d;
  logic             v1_q, v1_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [LED_W-1:0] leds_q, leds_d;
  logic             v2_q, v2_d;
  logic [OUT_W-1:0] out_next;
  logic             invalid;

  assign s1_in = '{
    a:         A,
    b:         B,
    opcode:    opcode_e'(opcode),
    cin:       cin,
    serial_in: serial_in,
    direction: direction,
    red_a:     red_op_A,
    red_b:     red_op_B,
    byp_a:     bypass_A,
    byp_b:     bypass_B
  };

  alsu_compute #(
    .INPUT_PRIORITY(INPUT_PRIORITY),
    .FULL_ADDER    (FULL_ADDER)
  ) u_compute (
    .s1_i      (s1_q),
    .out_i     (out_q),
    .out_next_o(out_next),
    .invalid_o (invalid)
  );

  always_comb begin
    s1_d = in_valid ? s1_in : s1_q;
    v1_d = in_valid;
  end

  // A stalled stage 2 holds out, so shift/rotate chains resume in place.
  always_comb begin
    out_d  = out_q;
    leds_d = leds_q;
    v2_d   = v1_q;
    if (v1_q) begin
      out_d  = out_next;
      leds_d = invalid ? ~leds_q : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      v1_q   <= 1'b0;
      out_q  <= '0;
      leds_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      v1_q   <= v1_d;
      out_q  <= out_d;
      leds_q <= leds_d;
      v2_q   <= v2_d;
    end
  end

  assign out       = out_q;
  assign leds      = leds_q;
  assign out_valid = v2_q;

endmodule
